cache_axi_bridge: RTL and testbench

Single-outstanding AXI4 master sitting directly downstream of the cache request arbiter. It accepts one word or block load/store command at a time and turns it into AR/R or AW/W/B transactions. It returns read data plus a one-cycle completion pulse to the arbiter. The block is the only AXI master port of the cache subsystem.

---
 rtl/cache_axi_bridge_pkg.sv | 23 ++
 rtl/cache_axi_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared command codes, AXI encodings and FSM state type for the cache AXI bridge.
package cache_axi_bridge_pkg;

    localparam logic [2:0] REQ_TO_AXI_NONE        = 3'd0;
    localparam logic [2:0] REQ_TO_AXI_LOAD_WORD   = 3'd1;
    localparam logic [2:0] REQ_TO_AXI_LOAD_BLOCK  = 3'd2;
    localparam logic [2:0] REQ_TO_AXI_WRITE_WORD  = 3'd3;
    localparam logic [2:0] REQ_TO_AXI_WRITE_BLOCK = 3'd4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5,
        ST_DONE    = 3'd6
    } bridge_state_t;

endpackage

// File: rtl/cache_axi_bridge.sv
// Single-outstanding AXI4 master turning cache word/block load/store commands into AR/R or AW/W/B bursts.
// Handshakes: a beat transfers on a rising edge where valid && ready; valid and payload are held stable until then.
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [2:0]                    req_to_axi,
    input  logic [ADDR_W-1:0]             ad_to_axi,
    input  logic [BLOCK_WORDS*DATA_W-1:0] wblock_to_axi,
    input  logic [DATA_W-1:0]             wword_to_axi,
    input  logic [DATA_W/8-1:0]           wword_en_to_axi,
    input  logic [2:0]                    rword_en_to_axi,
    output logic                          ready_from_axi,
    output logic                          task_finish_from_axi,
    output logic [BLOCK_WORDS*DATA_W-1:0] rblock_from_axi,
    output logic [DATA_W-1:0]             rword_from_axi,
    output logic [ADDR_W-1:0]             araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DATA_W-1:0]             wdata,
    output logic [DATA_W/8-1:0]           wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [2:0]                    o_dbg_state
);

    localparam int BLOCK_W = BLOCK_WORDS * DATA_W;
    localparam int STRB_W  = DATA_W / 8;
    localparam int CNT_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int BLK_OFF = $clog2(BLOCK_WORDS * STRB_W);
    localparam int WRD_OFF = $clog2(STRB_W);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [7:0]        BLK_LEN   = 8'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << BLK_OFF) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] WRD_MASK  = ~((ADDR_W'(1) << WRD_OFF) - ADDR_W'(1));

    bridge_state_t        r_state;
    bridge_state_t        w_next;
    logic                 r_blk;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_araddr;
    logic [7:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic [ADDR_W-1:0]    r_awaddr;
    logic [7:0]           r_awlen;
    logic [BLOCK_W-1:0]   r_wblock;
    logic [DATA_W-1:0]    r_wword;
    logic [STRB_W-1:0]    r_wstrb;
    logic [BLOCK_W-1:0]   r_rblock;
    logic [DATA_W-1:0]    r_rword;
    logic                 w_wlast;
    logic                 w_cnt_at_last;
    logic                 w_unused_resp;

    // Slave error responses carry no action here; completion is reported regardless.
    assign w_unused_resp = ^{rresp, bresp};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        ready_from_axi = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_to_axi != REQ_TO_AXI_NONE) begin
                    ready_from_axi = 1'b1;
                    case (req_to_axi)
                        REQ_TO_AXI_LOAD_WORD,
                        REQ_TO_AXI_LOAD_BLOCK:  w_next = ST_RD_ADDR;
                        REQ_TO_AXI_WRITE_WORD,
                        REQ_TO_AXI_WRITE_BLOCK: w_next = ST_WR_ADDR;
                        // Undefined codes are acknowledged and completed without bus traffic.
                        default:                w_next = ST_DONE;
                    endcase
                end
            end
            ST_RD_ADDR: if (arready)          w_next = ST_RD_DATA;
            ST_RD_DATA: if (rvalid && rlast)  w_next = ST_DONE;
            ST_WR_ADDR: if (awready)          w_next = ST_WR_DATA;
            ST_WR_DATA: if (wready && w_wlast) w_next = ST_WR_RESP;
            ST_WR_RESP: if (bvalid)           w_next = ST_DONE;
            ST_DONE:                          w_next = ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    assign w_cnt_at_last = (r_cnt == CNT_LAST);
    assign w_wlast       = r_blk ? w_cnt_at_last : 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_blk    <= 1'b0;
            r_cnt    <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_arsize <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_wblock <= '0;
            r_wword  <= '0;
            r_wstrb  <= '0;
            r_rblock <= '0;
            r_rword  <= '0;
        end else begin
            if (r_state == ST_IDLE && ready_from_axi) begin
                r_blk <= (req_to_axi == REQ_TO_AXI_LOAD_BLOCK) ||
                         (req_to_axi == REQ_TO_AXI_WRITE_BLOCK);
                r_cnt <= '0;
                case (req_to_axi)
                    REQ_TO_AXI_LOAD_WORD: begin
                        r_araddr <= ad_to_axi;
                        r_arlen  <= 8'd0;
                        r_arsize <= rword_en_to_axi;
                    end
                    REQ_TO_AXI_LOAD_BLOCK: begin
                        r_araddr <= ad_to_axi & BLK_MASK;
                        r_arlen  <= BLK_LEN;
                        r_arsize <= SIZE_WORD;
                    end
                    REQ_TO_AXI_WRITE_WORD: begin
                        r_awaddr <= ad_to_axi & WRD_MASK;
                        r_awlen  <= 8'd0;
                        r_wword  <= wword_to_axi;
                        r_wstrb  <= wword_en_to_axi;
                    end
                    REQ_TO_AXI_WRITE_BLOCK: begin
                        r_awaddr <= ad_to_axi & BLK_MASK;
                        r_awlen  <= BLK_LEN;
                        r_wblock <= wblock_to_axi;
                    end
                    default: ;
                endcase
            end
            // The beat counter saturates so a slave sending extra beats cannot index past the block.
            if (r_state == ST_RD_DATA && rvalid) begin
                if (r_blk) begin
                    r_rblock[r_cnt*DATA_W +: DATA_W] <= rdata;
                    if (!w_cnt_at_last) r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_rword <= rdata;
                end
            end
            if (r_state == ST_WR_DATA && wready && r_blk && !w_cnt_at_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign arvalid              = (r_state == ST_RD_ADDR);
    assign rready               = (r_state == ST_RD_DATA);
    assign awvalid              = (r_state == ST_WR_ADDR);
    assign wvalid               = (r_state == ST_WR_DATA);
    assign bready               = (r_state == ST_WR_RESP);
    assign task_finish_from_axi = (r_state == ST_DONE);

    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = BURST_INCR;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;

    assign wdata = r_blk ? r_wblock[r_cnt*DATA_W +: DATA_W] : r_wword;
    assign wstrb = r_blk ? {STRB_W{1'b1}} : r_wstrb;
    assign wlast = w_wlast;

    assign rblock_from_axi = r_rblock;
    assign rword_from_axi  = r_rword;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: a cycle-stepped AXI slave model plus scoreboards for W beats and read results.
`timescale 1ns/1ps
module tb_cache_axi_bridge;

    localparam logic [2:0] REQ_NONE        = 3'd0;
    localparam logic [2:0] REQ_LOAD_WORD   = 3'd1;
    localparam logic [2:0] REQ_LOAD_BLOCK  = 3'd2;
    localparam logic [2:0] REQ_WRITE_WORD  = 3'd3;
    localparam logic [2:0] REQ_WRITE_BLOCK = 3'd4;
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_RD_DATA      = 3'd2;

    // ---------------- clock / reset / DUT ----------------
    logic         clk;
    logic         rstn;
    logic [2:0]   req_to_axi;
    logic [31:0]  ad_to_axi;
    logic [127:0] wblock_to_axi;
    logic [31:0]  wword_to_axi;
    logic [3:0]   wword_en_to_axi;
    logic [2:0]   rword_en_to_axi;
    logic         ready_from_axi;
    logic         task_finish_from_axi;
    logic [127:0] rblock_from_axi;
    logic [31:0]  rword_from_axi;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [2:0]   dbg_state;

    cache_axi_bridge #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_to_axi(req_to_axi), .ad_to_axi(ad_to_axi), .wblock_to_axi(wblock_to_axi),
        .wword_to_axi(wword_to_axi), .wword_en_to_axi(wword_en_to_axi), .rword_en_to_axi(rword_en_to_axi),
        .ready_from_axi(ready_from_axi), .task_finish_from_axi(task_finish_from_axi),
        .rblock_from_axi(rblock_from_axi), .rword_from_axi(rword_from_axi),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / slave state ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [36:0]  exp_q[$];      // {wlast, wstrb, wdata} per expected W beat
    logic [127:0] exp_rd_q[$];   // expected read result per completed load
    int rd_kind = 0;             // 0 none, 1 word, 2 block

    int cfg_ar_delay, cfg_aw_delay, cfg_r_gap, cfg_b_delay;
    logic [3:0]  cfg_w_pat;
    logic [1:0]  cfg_bresp;
    logic [31:0] r_beats [0:3];
    int sl_r_n;

    int sl_ar_wait, sl_aw_wait, sl_w_cyc, sl_b_wait, sl_r_idx, sl_r_gap_cnt;
    int sl_r_hs, sl_w_hs, sl_b_hs, sl_b_rdy, fin_cnt, fin_cyc, accept_cyc, ar_cycles, aw_cycles;
    logic ar_changed, aw_changed, obs_ready;
    logic [42:0] ar_first;
    logic [39:0] aw_first;
    logic [31:0] obs_araddr, obs_awaddr;
    logic [7:0]  obs_arlen, obs_awlen;
    logic [2:0]  obs_arsize, obs_awsize;

    task automatic clr();
        cfg_ar_delay = 0; cfg_aw_delay = 0; cfg_r_gap = 0; cfg_b_delay = 0;
        cfg_w_pat = 4'hF; cfg_bresp = 2'd0; sl_r_n = 0;
        sl_ar_wait = 0; sl_aw_wait = 0; sl_w_cyc = 0; sl_b_wait = 0; sl_r_idx = 0; sl_r_gap_cnt = 0;
        sl_r_hs = 0; sl_w_hs = 0; sl_b_hs = 0; sl_b_rdy = 0; fin_cnt = 0; fin_cyc = 0;
        ar_cycles = 0; aw_cycles = 0; ar_changed = 1'b0; aw_changed = 1'b0;
        obs_araddr = '0; obs_awaddr = '0; obs_arlen = '0; obs_awlen = '0; obs_arsize = '0; obs_awsize = '0;
    endtask

    // One cycle: observe DUT at negedge, then drive the slave response for the coming posedge.
    task automatic tick();
        logic [127:0] exp_rd, got_rd;
        logic [36:0]  exp_w;
        @(negedge clk);
        cyc++;
        if (task_finish_from_axi) begin
            fin_cnt++;
            fin_cyc = cyc;
            if (rd_kind != 0) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_data: completion with no queued expectation");
                end else begin
                    exp_rd = exp_rd_q.pop_front();
                    got_rd = (rd_kind == 1) ? {96'd0, rword_from_axi} : rblock_from_axi;
                    if (got_rd !== exp_rd) begin
                        failures++;
                        $display("FAIL rd_data: got %h expected %h", got_rd, exp_rd);
                    end
                end
            end
        end
        if (arvalid) begin
            if (sl_ar_wait == 0) ar_first = {araddr, arlen, arsize};
            else if ({araddr, arlen, arsize} !== ar_first) ar_changed = 1'b1;
            arready = (sl_ar_wait >= cfg_ar_delay);
            sl_ar_wait++;
            if (arready) begin
                obs_araddr = araddr; obs_arlen = arlen; obs_arsize = arsize; ar_cycles = sl_ar_wait;
            end
        end else begin
            arready = 1'b0; sl_ar_wait = 0;
        end
        if (rready && sl_r_idx < sl_r_n) begin
            if (sl_r_idx > 0 && sl_r_gap_cnt < cfg_r_gap) begin
                rvalid = 1'b0; rlast = 1'b0; sl_r_gap_cnt++;
            end else begin
                rvalid = 1'b1; rdata = r_beats[sl_r_idx]; rlast = (sl_r_idx == sl_r_n - 1);
                rresp = 2'd0; sl_r_idx++; sl_r_gap_cnt = 0; sl_r_hs++;
            end
        end else begin
            rvalid = 1'b0; rlast = 1'b0;
        end
        if (awvalid) begin
            if (sl_aw_wait == 0) aw_first = {awaddr, awlen};
            else if ({awaddr, awlen} !== aw_first) aw_changed = 1'b1;
            awready = (sl_aw_wait >= cfg_aw_delay);
            sl_aw_wait++;
            if (awready) begin
                obs_awaddr = awaddr; obs_awlen = awlen; obs_awsize = awsize; aw_cycles = sl_aw_wait;
            end
        end else begin
            awready = 1'b0; sl_aw_wait = 0;
        end
        if (wvalid) begin
            wready = cfg_w_pat[2'(sl_w_cyc % 4)];
            sl_w_cyc++;
            if (wready) begin
                sl_w_hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL w_beat: unexpected beat %h", {wlast, wstrb, wdata});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({wlast, wstrb, wdata} !== exp_w) begin
                        failures++;
                        $display("FAIL w_beat: got {last,strb,data}=%h expected %h", {wlast, wstrb, wdata}, exp_w);
                    end
                end
            end
        end else begin
            wready = 1'b0;
        end
        if (bready) begin
            sl_b_rdy++;
            bvalid = (sl_b_wait >= cfg_b_delay);
            bresp = cfg_bresp;
            sl_b_wait++;
            if (bvalid) sl_b_hs++;
        end else begin
            bvalid = 1'b0; sl_b_wait = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] req, input logic [31:0] ad, input logic [127:0] wblk,
                         input logic [31:0] ww, input logic [3:0] strb, input logic [2:0] rsz);
        tick();
        req_to_axi = req; ad_to_axi = ad; wblock_to_axi = wblk;
        wword_to_axi = ww; wword_en_to_axi = strb; rword_en_to_axi = rsz;
        rd_kind = (req == REQ_LOAD_WORD) ? 1 : (req == REQ_LOAD_BLOCK) ? 2 : 0;
        #1;
        obs_ready = ready_from_axi;
        accept_cyc = cyc;
        tick();
        req_to_axi = REQ_NONE;
    endtask

    task automatic wait_done();
        int n = 0;
        int f0 = fin_cnt;
        while (fin_cnt == f0 && n < 300) begin
            tick();
            n++;
        end
        if (fin_cnt == f0) begin
            checks++; failures++;
            $display("FAIL done_timeout: no task_finish within %0d cycles", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, task_finish_from_axi, ready_from_axi} !== 7'd0) begin
            failures++;
            $display("FAIL reset_valids: got %b expected 0", {arvalid, rready, awvalid, wvalid, bready, task_finish_from_axi, ready_from_axi});
        end
        checks++;
        if ({araddr, arlen, awaddr, awlen} !== 80'd0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 0", {araddr, arlen, awaddr, awlen});
        end
        checks++;
        if ({rblock_from_axi, rword_from_axi} !== 160'd0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0", {rblock_from_axi, rword_from_axi});
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_load_word();
        clr();
        r_beats[0] = 32'hDEADBEEF; sl_r_n = 1;
        exp_rd_q.push_back({96'd0, 32'hDEADBEEF});
        issue(REQ_LOAD_WORD, 32'h1C00_0004, '0, '0, '0, 3'd2);
        wait_done();
        repeat (2) tick();
        checks++;
        if (obs_ready !== 1'b1) begin failures++; $display("FAIL lw_ready: got %b expected 1", obs_ready); end
        checks++;
        if ({obs_araddr, obs_arlen, obs_arsize} !== {32'h1C00_0004, 8'd0, 3'd2}) begin
            failures++;
            $display("FAIL lw_ar: got addr=%h len=%0d size=%0d expected 1c000004/0/2", obs_araddr, obs_arlen, obs_arsize);
        end
        checks++;
        if (fin_cyc - accept_cyc !== 3) begin failures++; $display("FAIL lw_latency: got %0d expected 3", fin_cyc - accept_cyc); end
        checks++;
        if (fin_cnt !== 1) begin failures++; $display("FAIL lw_finish_count: got %0d expected 1", fin_cnt); end
    endtask

    task automatic test_load_block();
        clr();
        r_beats[0] = 32'h11; r_beats[1] = 32'h22; r_beats[2] = 32'h33; r_beats[3] = 32'h44; sl_r_n = 4;
        exp_rd_q.push_back(128'h00000044_00000033_00000022_00000011);
        issue(REQ_LOAD_BLOCK, 32'h0000_1238, '0, '0, '0, 3'd0);
        wait_done();
        checks++;
        if ({obs_araddr, obs_arlen, obs_arsize} !== {32'h0000_1230, 8'd3, 3'd2}) begin
            failures++;
            $display("FAIL lb_ar: got addr=%h len=%0d size=%0d expected 00001230/3/2", obs_araddr, obs_arlen, obs_arsize);
        end
        checks++;
        if (fin_cyc - accept_cyc !== 6) begin failures++; $display("FAIL lb_latency: got %0d expected 6", fin_cyc - accept_cyc); end
        checks++;
        if (rword_from_axi !== 32'hDEADBEEF) begin failures++; $display("FAIL lb_rword_hold: got %h expected deadbeef", rword_from_axi); end
    endtask

    task automatic test_write_word();
        clr();
        cfg_aw_delay = 5;
        exp_q.push_back({1'b1, 4'b1000, 32'hA5A5A5A5});
        issue(REQ_WRITE_WORD, 32'h0000_8003, '0, 32'hA5A5A5A5, 4'b1000, 3'd0);
        wait_done();
        repeat (2) tick();
        checks++;
        if ({obs_awaddr, obs_awlen, obs_awsize} !== {32'h0000_8000, 8'd0, 3'd2}) begin
            failures++;
            $display("FAIL ww_aw: got addr=%h len=%0d size=%0d expected 00008000/0/2", obs_awaddr, obs_awlen, obs_awsize);
        end
        checks++;
        if (aw_changed !== 1'b0 || aw_cycles !== 6) begin
            failures++;
            $display("FAIL ww_aw_hold: changed=%b cycles=%0d expected 0/6", aw_changed, aw_cycles);
        end
        checks++;
        if (sl_b_hs !== 1 || fin_cnt !== 1) begin
            failures++;
            $display("FAIL ww_complete: b=%0d finish=%0d expected 1/1", sl_b_hs, fin_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL ww_beats_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_write_block();
        logic [127:0] blk;
        clr();
        cfg_w_pat = 4'b0101;
        cfg_b_delay = 2;
        for (int i = 0; i < 4; i++) begin
            blk[i*32 +: 32] = $urandom;
            exp_q.push_back({(i == 3), 4'hF, blk[i*32 +: 32]});
        end
        issue(REQ_WRITE_BLOCK, 32'h0004_567C, blk, '0, '0, 3'd0);
        wait_done();
        repeat (2) tick();
        checks++;
        if ({obs_awaddr, obs_awlen} !== {32'h0004_5670, 8'd3}) begin
            failures++;
            $display("FAIL wb_aw: got addr=%h len=%0d expected 00045670/3", obs_awaddr, obs_awlen);
        end
        checks++;
        if (sl_w_hs !== 4 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL wb_beats: handshakes=%0d left=%0d expected 4/0", sl_w_hs, exp_q.size());
        end
        checks++;
        if (sl_b_rdy !== 3 || sl_b_hs !== 1 || fin_cnt !== 1) begin
            failures++;
            $display("FAIL wb_resp: bready_cycles=%0d b=%0d finish=%0d expected 3/1/1", sl_b_rdy, sl_b_hs, fin_cnt);
        end
    endtask

    task automatic test_stall_err();
        logic [127:0] blk;
        clr();
        cfg_r_gap = 3;
        for (int i = 0; i < 4; i++) begin
            r_beats[i] = $urandom_range(32'h0000_0001, 32'hFFFF_FFFE);
            blk[i*32 +: 32] = r_beats[i];
        end
        sl_r_n = 4;
        exp_rd_q.push_back(blk);
        issue(REQ_LOAD_BLOCK, 32'h0000_2004, '0, '0, '0, 3'd0);
        wait_done();
        repeat (3) tick();
        checks++;
        if (fin_cyc - accept_cyc !== 15) begin failures++; $display("FAIL stall_latency: got %0d expected 15", fin_cyc - accept_cyc); end
        checks++;
        if (sl_r_hs !== 4 || fin_cnt !== 1) begin
            failures++;
            $display("FAIL stall_beats: r=%0d finish=%0d expected 4/1", sl_r_hs, fin_cnt);
        end
        clr();
        cfg_bresp = 2'd2;
        exp_q.push_back({1'b1, 4'b0011, 32'h0BAD_F00D});
        issue(REQ_WRITE_WORD, 32'h0000_0040, '0, 32'h0BAD_F00D, 4'b0011, 3'd0);
        wait_done();
        repeat (2) tick();
        checks++;
        if (fin_cyc - accept_cyc !== 4) begin failures++; $display("FAIL err_latency: got %0d expected 4", fin_cyc - accept_cyc); end
        checks++;
        if (sl_b_hs !== 1 || fin_cnt !== 1) begin
            failures++;
            $display("FAIL err_complete: b=%0d finish=%0d expected 1/1", sl_b_hs, fin_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk;
        logic [31:0]  word;
        int first_fin;
        clr();
        for (int i = 0; i < 4; i++) begin
            blk[i*32 +: 32] = $urandom;
            exp_q.push_back({(i == 3), 4'hF, blk[i*32 +: 32]});
        end
        issue(REQ_WRITE_BLOCK, 32'h0000_9010, blk, '0, '0, 3'd0);
        wait_done();
        checks++;
        if (fin_cyc - accept_cyc !== 7) begin failures++; $display("FAIL b2b_wb_latency: got %0d expected 7", fin_cyc - accept_cyc); end
        first_fin = fin_cyc;
        word = $urandom;
        r_beats[0] = word; sl_r_n = 1; sl_r_idx = 0;
        exp_rd_q.push_back({96'd0, word});
        issue(REQ_LOAD_WORD, 32'h0000_3001, '0, '0, '0, 3'd0);
        checks++;
        if (obs_ready !== 1'b1 || accept_cyc - first_fin !== 1) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b gap=%0d expected 1/1", obs_ready, accept_cyc - first_fin);
        end
        wait_done();
        checks++;
        if ({obs_araddr, obs_arlen, obs_arsize} !== {32'h0000_3001, 8'd0, 3'd0}) begin
            failures++;
            $display("FAIL b2b_ar: got addr=%h len=%0d size=%0d expected 00003001/0/0", obs_araddr, obs_arlen, obs_arsize);
        end
        checks++;
        if (fin_cyc - accept_cyc !== 3 || fin_cnt !== 2) begin
            failures++;
            $display("FAIL b2b_lw: latency=%0d finish=%0d expected 3/2", fin_cyc - accept_cyc, fin_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clr();
        cfg_r_gap = 3;
        for (int i = 0; i < 4; i++) r_beats[i] = 32'hC0DE_0000 + i;
        sl_r_n = 4;
        exp_rd_q.push_back('0);
        issue(REQ_LOAD_BLOCK, 32'h0000_5000, '0, '0, '0, 3'd0);
        while (!(dbg_state == ST_RD_DATA && sl_r_hs >= 2) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (dbg_state !== ST_RD_DATA) begin failures++; $display("FAIL mid_reach: got state %0d expected %0d", dbg_state, ST_RD_DATA); end
        rstn = 1'b0;
        tick();
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, task_finish_from_axi} !== 6'd0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL mid_abort: valids=%b state=%0d expected 0/%0d",
                     {arvalid, rready, awvalid, wvalid, bready, task_finish_from_axi}, dbg_state, ST_IDLE);
        end
        checks++;
        if ({rblock_from_axi, rword_from_axi} !== 160'd0) begin
            failures++;
            $display("FAIL mid_rdata_clear: got %h expected 0", {rblock_from_axi, rword_from_axi});
        end
        rstn = 1'b1;
        exp_rd_q.delete();
        clr();
        r_beats[0] = 32'h1234_5678; sl_r_n = 1;
        exp_rd_q.push_back({96'd0, 32'h1234_5678});
        issue(REQ_LOAD_WORD, 32'h0000_6004, '0, '0, '0, 3'd2);
        wait_done();
        checks++;
        if (fin_cyc - accept_cyc !== 3 || fin_cnt !== 1) begin
            failures++;
            $display("FAIL mid_recover: latency=%0d finish=%0d expected 3/1", fin_cyc - accept_cyc, fin_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0;
        req_to_axi = REQ_NONE; ad_to_axi = '0; wblock_to_axi = '0;
        wword_to_axi = '0; wword_en_to_axi = '0; rword_en_to_axi = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        clr();
        test_reset();
        test_load_word();
        test_load_block();
        test_write_word();
        test_write_block();
        test_stall_err();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
